ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have the ports: clk_in in 1, system clock; all state on rising edge.
REQ-002 The block SHALL have the port rst_in in 1, one clock only, reset asynchronous and active-low.
REQ-003 The block SHALL have the ports: rdy_in in 1, pause when low; flush_in in 1, jump/flush of instruction stream.
REQ-004 The block SHALL have the instruction-port signals: inst_req_in in 1; inst_addr_in in 32; inst_valid_out out 1; inst_data_out out 32.
REQ-005 The block SHALL have the data-port signals: data_req_in in 1; data_we_in in 1 (1=write); data_width_in in 3 (bytes: 1, 2, 4); data_addr_in in 32; data_wdata_in in 32; data_valid_out out 1; data_rdata_out out 32.
REQ-006 The block SHALL have the RAM-bus signals: ram_din in 8; ram_dout out 8; ram_a out 32; ram_wr out 1 (1=write); io_buffer_full in 1.

Function
REQ-007 The block SHALL implement states IDLE, INST_RD, DATA_RD, DATA_WR; exactly one access SHALL be in flight.
REQ-008 The block SHALL sample requests only in IDLE, and SHALL not sample them in any cycle where inst_valid_out or data_valid_out is high.
REQ-009 When data_req_in and inst_req_in are both high in IDLE, the block SHALL grant data; an access in progress SHALL never be preempted.
REQ-010 Each requester SHALL hold its request and operands stable until its valid pulse; the block SHALL latch the address, width and wdata at grant.
REQ-011 data_width_in SHALL encode 1/2/4 bytes; any other value SHALL be treated as 4; instruction fetch SHALL always read 4 bytes.
REQ-012 Byte i (i=0..n-1) SHALL be driven on ram_a = base+i in access cycle i, where cycle 0 is the cycle after grant.
REQ-013 Read: the byte addressed in cycle i SHALL be captured from ram_din in cycle i+1, assembled little-endian (byte i into bits 8i+7:8i), with upper bytes zero-filled.
REQ-014 Read completion: the valid output SHALL be a registered one-cycle pulse in cycle n+1, and rdata SHALL hold the assembled value until the next completion on that port.
REQ-015 Write: in cycle i the block SHALL drive ram_wr=1 and ram_dout = wdata bits 8i+7:8i, and SHALL pulse data_valid_out in cycle n.
REQ-016 IO write (base[17:16]==2'b11): while io_buffer_full=1, the block SHALL not issue the byte, SHALL keep ram_wr=0, and SHALL not advance the byte index; it SHALL issue once the flag is low.
REQ-017 flush_in=1 during INST_RD SHALL abort the fetch at the next edge: no inst_valid_out, return to IDLE.
REQ-018 flush_in=1 in IDLE SHALL cause the block to ignore inst_req_in that cycle, while data_req_in is still granted.
REQ-019 flush_in SHALL have no effect on data accesses.
REQ-020 rdy_in=0 SHALL freeze all state, counters and outputs, except ram_wr, which SHALL be forced to 0.
REQ-021 In IDLE the block SHALL drive ram_wr=0, ram_a=0 and ram_dout=0.
REQ-022 Read accesses SHALL drive ram_wr=0 throughout.

Reset
REQ-023 rst_in=0 SHALL immediately force state IDLE, byte index 0, ram_wr=0, ram_a=0, ram_dout=0, both valid outputs 0, and both data outputs 0.
REQ-024 Reset mid-access SHALL discard the access without a valid pulse; the first grant SHALL occur no earlier than the first rising edge with rst_in=1.

Verification
REQ-025 Fetch: inst_req_in=1 with addr 0x0000_1000, RAM bytes 13,05,00,00 -> ram_a 0x1000..0x1003 over 4 cycles, then inst_valid_out pulse with 0x0000_0513 in cycle 5.
REQ-026 Contention: inst and data read (width 2, addr 0x200, bytes AB,CD) both requested in the same IDLE cycle -> data served first with rdata 0x0000_CDAB, then the fetch begins after the data valid cycle.
REQ-027 Store: width 4, addr 0x100, wdata 0xDEADBEEF -> ram_wr=1 with dout EF,BE,AD,DE at 0x100..0x103, and data_valid_out pulse in cycle 4.
REQ-028 IO: byte write 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> ram_wr stays 0 for those cycles, then one write of 0x41, then valid.
REQ-029 Flush: flush_in pulsed in cycle 2 of a fetch -> no inst_valid_out, IDLE next cycle, and a new fetch to a new address completes normally.
REQ-030 Pause/reset: rdy_in=0 for 2 cycles mid-read -> the result is identical, delayed by 2 cycles; rst_in=0 mid-write -> ram_wr=0 immediately and no valid pulse.

Source files
------------

// File: rtl/ram_arbiter.sv
// Byte-serial RAM arbiter: one instruction-fetch port and one load/store port
// share an 8-bit synchronous RAM bus, with data accesses taking priority.
module ram_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        inst_req_in,
  input  logic [31:0] inst_addr_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_data_out,
  input  logic        data_req_in,
  input  logic        data_we_in,
  input  logic [2:0]  data_width_in,
  input  logic [31:0] data_addr_in,
  input  logic [31:0] data_wdata_in,
  output logic        data_valid_out,
  output logic [31:0] data_rdata_out,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INST_RD = 2'd1,
    DATA_RD = 2'd2,
    DATA_WR = 2'd3
  } state_t;

  function automatic logic [2:0] width_len(input logic [2:0] w);
    case (w)
      3'd1:    width_len = 3'd1;
      3'd2:    width_len = 3'd2;
      default: width_len = 3'd4;
    endcase
  endfunction

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [2:0]  r_len;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic        r_io;
  logic [31:0] r_buf;
  logic [31:0] r_ram_a;
  logic [7:0]  r_ram_dout;
  logic        r_ram_wr;
  logic        r_inst_valid;
  logic [31:0] r_inst_data;
  logic        r_data_valid;
  logic [31:0] r_data_rdata;

  state_t      w_state_nxt;
  logic [2:0]  w_idx_nxt;
  logic [2:0]  w_len_nxt;
  logic [31:0] w_base_nxt;
  logic [31:0] w_wdata_nxt;
  logic        w_io_nxt;
  logic [31:0] w_buf_nxt;
  logic [31:0] w_ram_a_nxt;
  logic [7:0]  w_ram_dout_nxt;
  logic        w_ram_wr_nxt;
  logic        w_inst_valid_nxt;
  logic [31:0] w_inst_data_nxt;
  logic        w_data_valid_nxt;
  logic [31:0] w_data_rdata_nxt;

  logic [2:0]  w_idx_inc;
  logic [2:0]  w_idx_dec;
  logic [5:0]  w_rd_shift;
  logic [5:0]  w_wr_shift;
  logic [31:0] w_rd_word;
  logic [31:0] w_wr_shifted;
  logic [31:0] w_next_addr;
  logic        w_io_stall;
  logic        w_can_grant;

  // Byte lane arithmetic: the byte read in cycle i-1 arrives now on ram_din.
  assign w_idx_inc    = r_idx + 3'd1;
  assign w_idx_dec    = r_idx - 3'd1;
  assign w_rd_shift   = {w_idx_dec, 3'b000};
  assign w_wr_shift   = {w_idx_inc, 3'b000};
  assign w_rd_word    = r_buf | ({24'h000000, ram_din} << w_rd_shift);
  assign w_wr_shifted = r_wdata >> w_wr_shift;
  assign w_next_addr  = r_base + {29'h00000000, w_idx_inc};
  assign w_io_stall   = r_io & io_buffer_full;
  assign w_can_grant  = ~r_inst_valid & ~r_data_valid;

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_len_nxt        = r_len;
    w_base_nxt       = r_base;
    w_wdata_nxt      = r_wdata;
    w_io_nxt         = r_io;
    w_buf_nxt        = r_buf;
    w_ram_a_nxt      = 32'h00000000;
    w_ram_dout_nxt   = 8'h00;
    w_ram_wr_nxt     = 1'b0;
    w_inst_valid_nxt = 1'b0;
    w_inst_data_nxt  = r_inst_data;
    w_data_valid_nxt = 1'b0;
    w_data_rdata_nxt = r_data_rdata;
    case (r_state)
      IDLE: begin
        w_idx_nxt = 3'd0;
        if (w_can_grant && data_req_in) begin
          w_state_nxt    = data_we_in ? DATA_WR : DATA_RD;
          w_len_nxt      = width_len(data_width_in);
          w_base_nxt     = data_addr_in;
          w_wdata_nxt    = data_wdata_in;
          w_io_nxt       = (data_addr_in[17:16] == 2'b11);
          w_buf_nxt      = 32'h00000000;
          w_ram_a_nxt    = data_addr_in;
          w_ram_wr_nxt   = data_we_in;
          w_ram_dout_nxt = data_we_in ? data_wdata_in[7:0] : 8'h00;
        end else if (w_can_grant && inst_req_in && !flush_in) begin
          w_state_nxt = INST_RD;
          w_len_nxt   = 3'd4;
          w_base_nxt  = inst_addr_in;
          w_io_nxt    = 1'b0;
          w_buf_nxt   = 32'h00000000;
          w_ram_a_nxt = inst_addr_in;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      INST_RD, DATA_RD: begin
        if (r_state == INST_RD && flush_in) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = 3'd0;
        end else begin
          if (r_idx != 3'd0) begin
            w_buf_nxt = w_rd_word;
          end else begin
            w_buf_nxt = r_buf;
          end
          if (r_idx == r_len) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = 3'd0;
            if (r_state == INST_RD) begin
              w_inst_valid_nxt = 1'b1;
              w_inst_data_nxt  = w_rd_word;
            end else begin
              w_data_valid_nxt = 1'b1;
              w_data_rdata_nxt = w_rd_word;
            end
          end else begin
            w_idx_nxt = w_idx_inc;
            if (w_idx_inc < r_len) begin
              w_ram_a_nxt = w_next_addr;
            end else begin
              w_ram_a_nxt = 32'h00000000;
            end
          end
        end
      end
      DATA_WR: begin
        // A full IO buffer replays the current byte until it is accepted.
        if (w_io_stall) begin
          w_ram_a_nxt    = r_ram_a;
          w_ram_dout_nxt = r_ram_dout;
          w_ram_wr_nxt   = 1'b1;
        end else if (w_idx_inc == r_len) begin
          w_state_nxt      = IDLE;
          w_idx_nxt        = 3'd0;
          w_data_valid_nxt = 1'b1;
        end else begin
          w_idx_nxt      = w_idx_inc;
          w_ram_a_nxt    = w_next_addr;
          w_ram_dout_nxt = w_wr_shifted[7:0];
          w_ram_wr_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  // State and output registers; rdy_in low holds every register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= IDLE;
      r_idx        <= 3'd0;
      r_len        <= 3'd0;
      r_base       <= 32'h00000000;
      r_wdata      <= 32'h00000000;
      r_io         <= 1'b0;
      r_buf        <= 32'h00000000;
      r_ram_a      <= 32'h00000000;
      r_ram_dout   <= 8'h00;
      r_ram_wr     <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_data  <= 32'h00000000;
      r_data_valid <= 1'b0;
      r_data_rdata <= 32'h00000000;
    end else if (rdy_in) begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_len        <= w_len_nxt;
      r_base       <= w_base_nxt;
      r_wdata      <= w_wdata_nxt;
      r_io         <= w_io_nxt;
      r_buf        <= w_buf_nxt;
      r_ram_a      <= w_ram_a_nxt;
      r_ram_dout   <= w_ram_dout_nxt;
      r_ram_wr     <= w_ram_wr_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst_data  <= w_inst_data_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_data_rdata <= w_data_rdata_nxt;
    end
  end

  // The write strobe must drop in the very cycle of a pause or IO back-pressure.
  assign ram_wr         = r_ram_wr & rdy_in & ~w_io_stall;
  assign ram_a          = r_ram_a;
  assign ram_dout       = r_ram_dout;
  assign inst_valid_out = r_inst_valid;
  assign inst_data_out  = r_inst_data;
  assign data_valid_out = r_data_valid;
  assign data_rdata_out = r_data_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a one-cycle-latency byte RAM that
// shares the arbiter's rdy_in pause.
module tb_ram_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        inst_req_in;
  logic [31:0] inst_addr_in;
  logic        inst_valid_out;
  logic [31:0] inst_data_out;
  logic        data_req_in;
  logic        data_we_in;
  logic [2:0]  data_width_in;
  logic [31:0] data_addr_in;
  logic [31:0] data_wdata_in;
  logic        data_valid_out;
  logic [31:0] data_rdata_out;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_buffer_full;

  logic [7:0]  mem [0:262143];
  logic        pl_en;
  logic [17:0] pl_addr;
  logic [7:0]  pl_data;
  logic [31:0] wd;

  int checks = 0;
  int errors = 0;

  ram_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .inst_req_in(inst_req_in), .inst_addr_in(inst_addr_in),
    .inst_valid_out(inst_valid_out), .inst_data_out(inst_data_out),
    .data_req_in(data_req_in), .data_we_in(data_we_in),
    .data_width_in(data_width_in), .data_addr_in(data_addr_in),
    .data_wdata_in(data_wdata_in), .data_valid_out(data_valid_out),
    .data_rdata_out(data_rdata_out), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_a(ram_a), .ram_wr(ram_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_wr) mem[ram_a[17:0]] <= ram_dout;
    if (rdy_in) ram_din <= mem[ram_a[17:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load(input logic [17:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    nxt();
    pl_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full = 1'b0;
    inst_req_in = 1'b0; inst_addr_in = 32'h0;
    data_req_in = 1'b0; data_we_in = 1'b0; data_width_in = 3'd0;
    data_addr_in = 32'h0; data_wdata_in = 32'h0;
    pl_en = 1'b0; pl_addr = 18'h0; pl_data = 8'h0;

    load(18'h01000, 8'h13); load(18'h01001, 8'h05);
    load(18'h01002, 8'h00); load(18'h01003, 8'h00);
    load(18'h00200, 8'hAB); load(18'h00201, 8'hCD);
    load(18'h02000, 8'h78); load(18'h02001, 8'h56);
    load(18'h02002, 8'h34); load(18'h02003, 8'h12);
    #1;
    chk("rst_wr", 32'(ram_wr), 32'h0);
    chk("rst_a", ram_a, 32'h0);
    chk("rst_dout", 32'(ram_dout), 32'h0);
    chk("rst_ivalid", 32'(inst_valid_out), 32'h0);
    chk("rst_dvalid", 32'(data_valid_out), 32'h0);
    chk("rst_idata", inst_data_out, 32'h0);
    chk("rst_rdata", data_rdata_out, 32'h0);
    nxt(); rst_in = 1'b1;
    nxt();

    // Instruction fetch of 4 bytes at 0x1000
    inst_req_in = 1'b1; inst_addr_in = 32'h00001000;
    for (int i = 0; i < 4; i++) begin
      nxt(); #1;
      chk("fetch_a", ram_a, 32'h00001000 + 32'(i));
      chk("fetch_wr", 32'(ram_wr), 32'h0);
    end
    nxt(); #1; chk("fetch_early", 32'(inst_valid_out), 32'h0);
    nxt(); #1;
    chk("fetch_valid", 32'(inst_valid_out), 32'h1);
    chk("fetch_data", inst_data_out, 32'h00000513);
    inst_req_in = 1'b0;
    nxt(); #1;
    chk("fetch_pulse", 32'(inst_valid_out), 32'h0);
    chk("fetch_hold", inst_data_out, 32'h00000513);

    // Contention: data read of 2 bytes wins over fetch
    data_req_in = 1'b1; data_we_in = 1'b0; data_width_in = 3'd2; data_addr_in = 32'h00000200;
    inst_req_in = 1'b1; inst_addr_in = 32'h00001000;
    nxt(); #1; chk("cont_a0", ram_a, 32'h00000200);
    nxt(); #1; chk("cont_a1", ram_a, 32'h00000201);
    nxt(); #1; chk("cont_early", 32'(data_valid_out), 32'h0);
    nxt(); #1;
    chk("cont_dvalid", 32'(data_valid_out), 32'h1);
    chk("cont_rdata", data_rdata_out, 32'h0000CDAB);
    data_req_in = 1'b0;
    nxt(); #1; chk("cont_idle_a", ram_a, 32'h0);
    nxt(); #1; chk("cont_fetch_a0", ram_a, 32'h00001000);
    repeat (4) nxt();
    nxt(); #1;
    chk("cont_ivalid", 32'(inst_valid_out), 32'h1);
    chk("cont_idata", inst_data_out, 32'h00000513);
    chk("cont_rdata_hold", data_rdata_out, 32'h0000CDAB);
    inst_req_in = 1'b0;
    nxt();

    // Word store 0xDEADBEEF at 0x100
    wd = 32'hDEADBEEF;
    data_req_in = 1'b1; data_we_in = 1'b1; data_width_in = 3'd4;
    data_addr_in = 32'h00000100; data_wdata_in = wd;
    for (int i = 0; i < 4; i++) begin
      nxt(); #1;
      chk("st_wr", 32'(ram_wr), 32'h1);
      chk("st_a", ram_a, 32'h00000100 + 32'(i));
      chk("st_dout", 32'(ram_dout), 32'(wd[8*i +: 8]));
    end
    nxt(); #1;
    chk("st_valid", 32'(data_valid_out), 32'h1);
    chk("st_wr_end", 32'(ram_wr), 32'h0);
    data_req_in = 1'b0; data_we_in = 1'b0;
    nxt(); #1;
    chk("st_mem0", 32'(mem[18'h00100]), 32'h000000EF);
    chk("st_mem3", 32'(mem[18'h00103]), 32'h000000DE);

    // IO byte write held off by a full buffer
    data_req_in = 1'b1; data_we_in = 1'b1; data_width_in = 3'd1;
    data_addr_in = 32'h00030000; data_wdata_in = 32'h00000041; io_buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("io_stall_wr", 32'(ram_wr), 32'h0);
      chk("io_stall_valid", 32'(data_valid_out), 32'h0);
    end
    nxt(); io_buffer_full = 1'b0; #1;
    chk("io_wr", 32'(ram_wr), 32'h1);
    chk("io_dout", 32'(ram_dout), 32'h00000041);
    chk("io_a", ram_a, 32'h00030000);
    nxt(); #1;
    chk("io_valid", 32'(data_valid_out), 32'h1);
    chk("io_wr_end", 32'(ram_wr), 32'h0);
    data_req_in = 1'b0; data_we_in = 1'b0;
    nxt(); #1;
    chk("io_mem", 32'(mem[18'h30000]), 32'h00000041);

    // Flush in cycle 2 of a fetch, then refetch elsewhere
    inst_req_in = 1'b1; inst_addr_in = 32'h00001000;
    nxt(); nxt();
    nxt(); flush_in = 1'b1; #1; chk("fl_a2", ram_a, 32'h00001002);
    nxt(); flush_in = 1'b0; inst_addr_in = 32'h00002000; #1;
    chk("fl_novalid", 32'(inst_valid_out), 32'h0);
    chk("fl_idle_a", ram_a, 32'h0);
    chk("fl_data_hold", inst_data_out, 32'h00000513);
    nxt(); #1; chk("fl_new_a0", ram_a, 32'h00002000);
    repeat (4) nxt();
    #1; chk("fl_new_early", 32'(inst_valid_out), 32'h0);
    nxt(); #1;
    chk("fl_new_valid", 32'(inst_valid_out), 32'h1);
    chk("fl_new_data", inst_data_out, 32'h12345678);
    inst_req_in = 1'b0;
    nxt();

    // Flush in IDLE blocks a fetch grant but not a data grant
    inst_req_in = 1'b1; inst_addr_in = 32'h00001000; flush_in = 1'b1;
    nxt(); flush_in = 1'b0; inst_req_in = 1'b0; #1;
    chk("fli_nogrant", ram_a, 32'h0);
    inst_req_in = 1'b1; flush_in = 1'b1;
    data_req_in = 1'b1; data_we_in = 1'b0; data_width_in = 3'd1; data_addr_in = 32'h00000201;
    nxt(); flush_in = 1'b0; inst_req_in = 1'b0; #1;
    chk("fli_data_a", ram_a, 32'h00000201);
    nxt(); #1; chk("fli_early", 32'(data_valid_out), 32'h0);
    nxt(); #1;
    chk("fli_valid", 32'(data_valid_out), 32'h1);
    chk("fli_rdata", data_rdata_out, 32'h000000CD);
    data_req_in = 1'b0;
    nxt();

    // Two-cycle pause mid-read (width code 7 acts as 4 bytes)
    data_req_in = 1'b1; data_we_in = 1'b0; data_width_in = 3'd7; data_addr_in = 32'h00002000;
    nxt(); #1; chk("pz_a0", ram_a, 32'h00002000);
    nxt(); rdy_in = 1'b0; #1; chk("pz_a1", ram_a, 32'h00002001);
    nxt(); #1; chk("pz_a1_hold", ram_a, 32'h00002001);
    nxt(); rdy_in = 1'b1; #1; chk("pz_a1_resume", ram_a, 32'h00002001);
    nxt(); #1; chk("pz_a2", ram_a, 32'h00002002);
    nxt(); #1; chk("pz_a3", ram_a, 32'h00002003);
    nxt(); #1; chk("pz_early", 32'(data_valid_out), 32'h0);
    nxt(); #1;
    chk("pz_valid", 32'(data_valid_out), 32'h1);
    chk("pz_rdata", data_rdata_out, 32'h12345678);
    data_req_in = 1'b0;
    nxt();

    // Reset asserted in the second byte of a store
    data_req_in = 1'b1; data_we_in = 1'b1; data_width_in = 3'd4;
    data_addr_in = 32'h00000100; data_wdata_in = 32'h11223344;
    nxt(); #1;
    chk("rw_wr0", 32'(ram_wr), 32'h1);
    chk("rw_dout0", 32'(ram_dout), 32'h00000044);
    nxt(); #1;
    chk("rw_wr1", 32'(ram_wr), 32'h1);
    rst_in = 1'b0; data_req_in = 1'b0; data_we_in = 1'b0; #1;
    chk("rw_wr_rst", 32'(ram_wr), 32'h0);
    chk("rw_a_rst", ram_a, 32'h0);
    chk("rw_dout_rst", 32'(ram_dout), 32'h0);
    chk("rw_idata_rst", inst_data_out, 32'h0);
    nxt(); rst_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("rw_novalid", 32'(data_valid_out), 32'h0);
    end
    chk("rw_mem0", 32'(mem[18'h00100]), 32'h00000044);
    chk("rw_mem1", 32'(mem[18'h00101]), 32'h000000BE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
